sd_bidir_pio: RTL and testbench

Parametrised Avalon-MM bidirectional PIO for SD-card data/command lines, the successor of the fixed 4-bit SD DAT port. It adds configurable width, a metastability synchroniser on inputs, atomic set/clear of outputs, and edge capture with a maskable interrupt. It sits between the Avalon slave interconnect and the SD pads, and the NIOS bit-bang driver uses it for DAT[3:0] or CMD.

---
 rtl/sd_pio_pkg.sv | 21 ++
 rtl/sd_pio_sync.sv | 41 ++++
 rtl/sd_bidir_pio.sv | 154 +++++++++++++++
 tb/tb_sd_bidir_pio.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_pio_pkg.sv
// -----------------------------------------------------------------------------
// sd_pio_pkg
//   Shared definitions for the SD-card bidirectional PIO: the Avalon register
//   word addresses and the EDGE_MODE encodings used by sd_bidir_pio.
// -----------------------------------------------------------------------------
package sd_pio_pkg;

   // Register word addresses (3-bit Avalon address)
   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_DIR     = 3'd1;
   localparam logic [2:0] ADDR_IRQMASK = 3'd2;
   localparam logic [2:0] ADDR_EDGECAP = 3'd3;
   localparam logic [2:0] ADDR_OUTSET  = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

   // Edge capture selection
   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/sd_pio_sync.sv
// -----------------------------------------------------------------------------
// sd_pio_sync
//   WIDTH-bit x STAGES-deep metastability synchroniser. Each bit passes through
//   its own flop chain; output is the last stage, STAGES cycles after the input.
//   Ports:
//     clk      in   system clock
//     reset_n  in   synchronous active-low reset, clears every stage
//     d        in   asynchronous input bits (pads)
//     q        out  synchronised bits
// -----------------------------------------------------------------------------
module sd_pio_sync #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] stage_q;
   logic [STAGES-1:0][WIDTH-1:0] stage_d;

   // Stage 0 samples the pad, each later stage takes its predecessor.
   always_comb begin
      stage_d = {stage_q[STAGES-2:0], d};
   end

   // NOTE: sequential state uses <= so every stage samples pre-edge values;
   // blocking assignments here would collapse the chain into a single flop.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign q = stage_q[STAGES-1];

endmodule

// File: rtl/sd_bidir_pio.sv
// -----------------------------------------------------------------------------
// sd_bidir_pio
//   Avalon-MM bidirectional PIO for SD-card DAT/CMD lines. Per-pin direction,
//   atomic set/clear of outputs, synchronised inputs, edge capture with W1C
//   clear and a maskable level interrupt.
//   Ports:
//     clk, reset_n      clock, synchronous active-low reset
//     address[2:0]      register word address
//     chipselect        Avalon slave select
//     write_n           active-low write strobe
//     writedata[31:0]   write data, bits [WIDTH-1:0] used
//     readdata[31:0]    registered read data (latency 1), upper bits 0
//     irq               level interrupt, active high
//     bidir_port        pad pins, driven where the direction bit is 1
// -----------------------------------------------------------------------------
module sd_bidir_pio
   import sd_pio_pkg::*;
#(
   parameter int               WIDTH       = 4,
   parameter int               SYNC_STAGES = 2,
   parameter logic [WIDTH-1:0] RESET_DIR   = '0,
   parameter int               EDGE_MODE   = EDGE_RISE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             irq,
   inout  wire  [WIDTH-1:0] bidir_port
);

   // Settle counter runs 0..SETTLE_LAST after reset, then holds there.
   localparam int SETTLE_LAST = SYNC_STAGES + 1;
   localparam int CW          = $clog2(SETTLE_LAST + 1);

   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic [WIDTH-1:0] dir_q, dir_d;
   logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
   logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [CW-1:0]    settle_q, settle_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;

   logic [WIDTH-1:0] pad_in;
   logic [WIDTH-1:0] sync_in;
   logic [WIDTH-1:0] wd;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] edge_raw;
   logic [WIDTH-1:0] edge_det;
   logic [WIDTH-1:0] rd_word;
   logic             wr;
   logic             settled;
   logic             unused_wd;

   // Pads: drive only where the direction bit selects output; the input path
   // always samples the pad, so driven pins read back their own level.
   for (genvar i = 0; i < WIDTH; i++) begin : g_pad
      assign bidir_port[i] = dir_q[i] ? data_out_q[i] : 1'bz;
   end
   assign pad_in = bidir_port;

   sd_pio_sync #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (pad_in),
      .q       (sync_in)
   );

   assign wr        = chipselect & ~write_n;
   assign wd        = writedata[WIDTH-1:0];
   assign unused_wd = ^writedata;
   assign settled   = (settle_q == CW'(SETTLE_LAST));

   // NOTE: every always_comb output gets a default before any branch, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      data_out_d = data_out_q;
      dir_d      = dir_q;
      irq_mask_d = irq_mask_q;
      cap_clr    = '0;
      rd_word    = '0;

      if (wr) begin
         case (address)
            ADDR_DATA:    data_out_d = wd;
            ADDR_DIR:     dir_d      = wd;
            ADDR_IRQMASK: irq_mask_d = wd;
            ADDR_EDGECAP: cap_clr    = wd;
            ADDR_OUTSET:  data_out_d = data_out_q | wd;
            ADDR_OUTCLR:  data_out_d = data_out_q & ~wd;
            default:      ;
         endcase
      end

      if (EDGE_MODE == EDGE_FALL) begin
         edge_raw = ~sync_in & prev_q;
      end else if (EDGE_MODE == EDGE_ANY) begin
         edge_raw = sync_in ^ prev_q;
      end else begin
         edge_raw = sync_in & ~prev_q;
      end

      // Suppress edges until the synchroniser and prev hold real pad history.
      edge_det   = settled ? edge_raw : '0;
      // A new edge wins over a simultaneous W1C on the same bit.
      edge_cap_d = (edge_cap_q & ~cap_clr) | edge_det;
      irq_d      = |(edge_cap_q & irq_mask_q);
      prev_d     = sync_in;
      settle_d   = settled ? settle_q : settle_q + CW'(1);

      // Read mux uses pre-write register state.
      case (address)
         ADDR_DATA:    rd_word = sync_in;
         ADDR_DIR:     rd_word = dir_q;
         ADDR_IRQMASK: rd_word = irq_mask_q;
         ADDR_EDGECAP: rd_word = edge_cap_q;
         default:      rd_word = '0;
      endcase
      readdata_d = 32'(rd_word);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         data_out_q <= '0;
         dir_q      <= RESET_DIR;
         irq_mask_q <= '0;
         edge_cap_q <= '0;
         prev_q     <= '0;
         settle_q   <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         data_out_q <= data_out_d;
         dir_q      <= dir_d;
         irq_mask_q <= irq_mask_d;
         edge_cap_q <= edge_cap_d;
         prev_q     <= prev_d;
         settle_q   <= settle_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule

// File: tb/tb_sd_bidir_pio.sv
// -----------------------------------------------------------------------------
// tb_sd_bidir_pio
//   Scoreboard bench for sd_bidir_pio. Two instances share the Avalon bus and
//   see the same pad stimulus: u_dut_rise (EDGE_MODE rising) and u_dut_any
//   (EDGE_MODE any). Stimulus pushes expected values into queues; a monitor on
//   the falling clock edge pops and compares when a read result or probe is due.
// -----------------------------------------------------------------------------
module tb_sd_bidir_pio;
   import sd_pio_pkg::*;

   typedef struct {
      logic [31:0] exp;
      bit          sel;    // 0: rising-mode DUT, 1: any-mode DUT
      byte         kind;   // probes: 0 irq, 1 pads
      string       name;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] rdata0, rdata1;
   logic        irq0, irq1;
   wire  [3:0]  pads0, pads1;
   logic [3:0]  tb_oe;
   logic [3:0]  tb_val;
   logic        rd_issued = 1'b0;
   logic        probe_req = 1'b0;

   exp_t rd_q[$];
   exp_t pr_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   for (genvar i = 0; i < 4; i++) begin : g_drv
      assign pads0[i] = tb_oe[i] ? tb_val[i] : 1'bz;
      assign pads1[i] = tb_oe[i] ? tb_val[i] : 1'bz;
   end

   sd_bidir_pio #(
      .WIDTH(4), .SYNC_STAGES(2), .RESET_DIR(4'h0), .EDGE_MODE(EDGE_RISE)
   ) u_dut_rise (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rdata0), .irq(irq0),
      .bidir_port(pads0)
   );

   sd_bidir_pio #(
      .WIDTH(4), .SYNC_STAGES(2), .RESET_DIR(4'h0), .EDGE_MODE(EDGE_ANY)
   ) u_dut_any (
      .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(rdata1), .irq(irq1),
      .bidir_port(pads1)
   );

   // A read presented at a rising edge has its data valid after that edge.
   always @(posedge clk) rd_issued <= chipselect & write_n;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      logic [31:0] act;
      if (rd_issued) begin
         if (rd_q.size() == 0) begin
            check("read_without_expectation", rd_q.size(), 32'd1);
         end else begin
            e   = rd_q.pop_front();
            act = e.sel ? rdata1 : rdata0;
            check(e.name, act, e.exp);
         end
      end
      if (probe_req) begin
         if (pr_q.size() == 0) begin
            check("probe_without_expectation", pr_q.size(), 32'd1);
         end else begin
            e = pr_q.pop_front();
            if (e.kind == 0) act = {31'd0, (e.sel ? irq1 : irq0)};
            else             act = {28'd0, (e.sel ? pads1 : pads0)};
            check(e.name, act, e.exp);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input bit sel,
                           input string name);
      rd_q.push_back('{exp: exp, sel: sel, kind: 8'sd0, name: name});
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      tick();
      chipselect = 1'b0;
   endtask

   // Samples state as of the most recent rising edge.
   task automatic probe(input byte kind, input logic [31:0] exp, input bit sel,
                        input string name);
      pr_q.push_back('{exp: exp, sel: sel, kind: kind, name: name});
      probe_req = 1'b1;
      tick();
      probe_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n    = 1'b0;
      address    = '0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      tb_oe      = 4'hF;
      tb_val     = 4'hF;   // pins high through reset release

      repeat (2) tick();
      bus_read(ADDR_DATA, 32'h0, 0, "reset_readdata");
      bus_read(ADDR_DIR,  32'h0, 1, "reset_dir");
      probe(0, 32'h0, 0, "reset_irq");
      reset_n = 1'b1;

      repeat (10) tick();
      bus_read(ADDR_EDGECAP, 32'h0, 0, "no_false_edge_rise");
      bus_read(ADDR_EDGECAP, 32'h0, 1, "no_false_edge_any");
      bus_read(ADDR_DATA,    32'hF, 0, "data_in_high");
      bus_read(ADDR_DIR,     32'h0, 0, "dir_after_reset");

      // Falling edges: ignored in rising mode, captured in any mode
      tb_val = 4'h0;
      repeat (4) tick();
      bus_read(ADDR_EDGECAP, 32'h0, 0, "fall_ignored_rise_mode");
      bus_read(ADDR_EDGECAP, 32'hF, 1, "fall_captured_any_mode");
      bus_write(ADDR_EDGECAP, 32'hF);

      // Outputs: A | 1 & ~8 = 3
      bus_write(ADDR_DIR, 32'hF);
      tb_oe = 4'h0;
      bus_write(ADDR_DATA,   32'hA);
      bus_write(ADDR_OUTSET, 32'h1);
      bus_write(ADDR_OUTCLR, 32'h8);
      probe(1, 32'h3, 0, "pads_rise_dut");
      probe(1, 32'h3, 1, "pads_any_dut");
      bus_read(ADDR_DATA, 32'h3, 0, "data_readback_latency");
      repeat (2) tick();
      bus_read(ADDR_EDGECAP, 32'hB, 0, "cap_driven_rises");
      bus_read(ADDR_OUTSET, 32'h0, 0, "outset_reads_zero");
      bus_write(3'd6, 32'h0);
      bus_read(3'd7, 32'h0, 0, "addr7_reads_zero");
      bus_read(ADDR_DIR, 32'hF, 0, "dir_kept_after_addr6_write");
      bus_write(ADDR_EDGECAP, 32'hF);
      bus_read(ADDR_EDGECAP, 32'h0, 0, "w1c_all");

      // Back to inputs, mask pin 1
      tb_val = 4'h3;
      tb_oe  = 4'hF;
      bus_write(ADDR_DIR, 32'h0);
      bus_write(ADDR_IRQMASK, 32'h2);
      tb_val = 4'h0;
      repeat (4) tick();
      bus_write(ADDR_EDGECAP, 32'hF);
      bus_read(ADDR_EDGECAP, 32'h0, 1, "any_cleared_before_irq");

      // Pad 1 rises: capture on edge 3, irq on edge 4
      tb_val = 4'h2;
      repeat (3) tick();
      probe(0, 32'h0, 0, "irq_not_yet");
      probe(0, 32'h1, 0, "irq_cycle4");
      bus_read(ADDR_EDGECAP, 32'h2, 0, "cap_pad1_rise");
      bus_write(ADDR_EDGECAP, 32'h2);
      probe(0, 32'h1, 0, "irq_hold_at_clear_edge");
      probe(0, 32'h0, 0, "irq_cleared");

      // Pad 0 rise captured on the same edge as a W1C of bit 0
      tb_val = 4'h3;
      repeat (2) tick();
      bus_write(ADDR_EDGECAP, 32'h1);
      bus_read(ADDR_EDGECAP, 32'h1, 0, "set_wins_over_clear");
      probe(0, 32'h0, 0, "irq_masked_bit0");
      bus_write(ADDR_EDGECAP, 32'h1);
      bus_read(ADDR_EDGECAP, 32'h0, 0, "w1c_bit0");

      // Pad 3 toggles twice
      tb_val = 4'hB;
      repeat (3) tick();
      tb_val = 4'h3;
      repeat (4) tick();
      bus_read(ADDR_EDGECAP, 32'h8, 1, "any_toggle_pad3");
      bus_read(ADDR_EDGECAP, 32'h8, 0, "rise_toggle_pad3");
      bus_write(ADDR_IRQMASK, 32'h8);
      probe(0, 32'h0, 0, "irq_mask_write_lag");
      probe(0, 32'h1, 0, "irq_mask_on");
      bus_read(ADDR_IRQMASK, 32'h8, 0, "irqmask_rw");
      bus_write(ADDR_DATA, 32'h5);

      // One-clock reset mid-operation
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      probe(0, 32'h0, 1, "irq_after_reset");
      bus_read(ADDR_EDGECAP, 32'h0, 1, "cap_after_reset");
      bus_read(ADDR_IRQMASK, 32'h0, 0, "mask_after_reset");
      repeat (10) tick();
      bus_read(ADDR_EDGECAP, 32'h0, 1, "no_false_edge_after_reset");
      tb_val = 4'h0;
      tick();
      bus_write(ADDR_DIR, 32'hF);
      tb_oe = 4'h0;
      probe(1, 32'h0, 0, "data_out_after_reset");

      repeat (3) tick();
      check("queues_drained", rd_q.size() + pr_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
